hazard_scoreboard: RTL and testbench

Parametrised hazard-control block for the 5-stage pipelined MIPS core (IF, ID, EX, MEM, WB). It tracks in-flight destination registers in a shift-register scoreboard and drives three kinds of control:
- load-use and RAW stalls for the PC and IF/ID register;
- forwarding selects for the ID and EX operand muxes;
- pipeline flushes when a branch resolves taken in MEM.

A mode parameter selects full forwarding or stall-only operation. Saturating counters record stalls and flushes.

---
 rtl/hazard_scoreboard_pkg.sv | 40 ++++
 rtl/hazard_scoreboard_sb_match.sv | 31 +++
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the hazard scoreboard of the 5-stage MIPS core:
//   - EX forwarding-select encodings (operand source for the EX muxes)
//   - sbEntry: one scoreboard slot {valid, dest, isLoad}
//   - exFwdSelect: priority function choosing the EX operand source
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  // EX operand mux select encodings
  localparam logic [1:0] FWD_SRC_IDEX  = 2'd0;
  localparam logic [1:0] FWD_SRC_EXMEM = 2'd1;
  localparam logic [1:0] FWD_SRC_MEMWB = 2'd2;

  // Scoreboard geometry. The dest field is sized for the widest register
  // address the core is expected to use; narrower addresses are zero-extended
  // on entry so every comparison happens at this common width.
  localparam int SB_DEPTH  = 3;
  localparam int SB_DEST_W = 8;

  // One in-flight instruction. valid is only set for real instructions that
  // write the register file, so a slot holding a store/branch reads as empty.
  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 isLoad;
  } sbEntry;

  // Youngest producer wins: the instruction in EX beats the one in MEM.
  // A load in EX cannot be bypassed from EX/MEM (its data is not there yet);
  // that case is covered by the load-use stall, so it falls through here.
  function automatic logic [1:0] exFwdSelect(input logic matchEx,
                                             input logic exIsLoad,
                                             input logic matchMem);
    if (matchEx && !exIsLoad) return FWD_SRC_EXMEM;
    if (matchMem)             return FWD_SRC_MEMWB;
    return FWD_SRC_IDEX;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Compares one source register of the instruction in ID against one
// scoreboard entry.
// Ports:
//   srcUsed  in   source register is actually read by the ID instruction
//   src      in   source register number
//   entry    in   scoreboard slot to compare against
//   match    out  1 when the source is used, the entry is live and the
//                 register numbers are equal (register 0 never matches)
// -----------------------------------------------------------------------------
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  srcUsed,
  input  logic [REG_ADDR_W-1:0] src,
  input  sbEntry                entry,
  output logic                  match
);

  logic [SB_DEST_W-1:0] srcExt;

  assign srcExt = SB_DEST_W'(src);

  // $zero is hard-wired, so a producer targeting it is never a hazard source
  assign match = srcUsed && entry.valid && (entry.dest != '0) &&
                 (entry.dest == srcExt);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Hazard control for the 5-stage MIPS pipeline. A 3-deep shift-register
// scoreboard tracks the destinations of the instructions in EX, MEM and WB
// and drives stalls, ID/EX forwarding selects and branch flushes.
// Parameters:
//   REG_ADDR_W  register-address width
//   FWD_EN      1 = full forwarding, 0 = stall on every RAW, no bypass
//   CNT_W       width of the saturating performance counters
// Ports:
//   clk, reset                  core clock, synchronous active-low reset
//   id_*                        decoded fields of the instruction in ID
//   mem_branch_taken            branch in MEM resolved taken this cycle
//   stall                       hold PC and IF/ID, bubble into ID/EX
//   flush_if_id/id_ex/ex_mem    clear that pipeline register at next edge
//   id_fwd_a/b                  ID operand takes the WB write data
//   ex_fwd_a/b                  registered EX operand select (pkg encodings)
//   stall_cnt, flush_cnt        saturating stall / flush cycle counters
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  mem_branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  id_fwd_a,
  output logic                  id_fwd_b,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam bit              FWD_ON  = (FWD_EN != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // sb[0] = EX, sb[1] = MEM, sb[2] = WB
  sbEntry sb [SB_DEPTH];

  logic [SB_DEPTH-1:0] matchA;
  logic [SB_DEPTH-1:0] matchB;
  logic                useA;
  logic                useB;
  logic                stallReq;
  logic                enterValid;
  logic [1:0]          nextFwdA;
  logic [1:0]          nextFwdB;
  sbEntry              newEntry;

  // A non-valid ID slot holds garbage fields and must not raise hazards
  assign useA = id_valid && id_uses_rs;
  assign useB = id_valid && id_uses_rt;

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : gMatch
      sb_match #(.REG_ADDR_W(REG_ADDR_W)) uMatchA (
        .srcUsed(useA),
        .src    (id_rs),
        .entry  (sb[gi]),
        .match  (matchA[gi])
      );
      sb_match #(.REG_ADDR_W(REG_ADDR_W)) uMatchB (
        .srcUsed(useB),
        .src    (id_rt),
        .entry  (sb[gi]),
        .match  (matchB[gi])
      );
    end
  endgenerate

  // Hazard decision. With forwarding only a load directly ahead needs a
  // bubble; without it any in-flight producer blocks until it has left WB.
  always_comb begin
    stallReq = 1'b0;
    nextFwdA = FWD_SRC_IDEX;
    nextFwdB = FWD_SRC_IDEX;
    if (FWD_ON) begin
      stallReq = (matchA[0] || matchB[0]) && sb[0].isLoad;
      nextFwdA = exFwdSelect(matchA[0], sb[0].isLoad, matchA[1]);
      nextFwdB = exFwdSelect(matchB[0], sb[0].isLoad, matchB[1]);
    end else begin
      stallReq = (|matchA) || (|matchB);
    end
  end

  // Combinational outputs are silenced during reset; a taken branch
  // overrides any stall because the stalled instruction is being squashed.
  assign stall        = reset && !mem_branch_taken && stallReq;
  assign flush_if_id  = reset && mem_branch_taken;
  assign flush_id_ex  = reset && mem_branch_taken;
  assign flush_ex_mem = reset && mem_branch_taken;

  // The register file writes at the same edge ID reads it, so a producer
  // in WB has to be bypassed straight into the ID operand.
  assign id_fwd_a = FWD_ON && reset && matchA[2];
  assign id_fwd_b = FWD_ON && reset && matchB[2];

  // What enters EX at the next edge: a bubble on stall, flush or empty ID
  assign enterValid = id_valid && !stall && !mem_branch_taken;

  always_comb begin
    newEntry        = '0;
    newEntry.valid  = enterValid && id_reg_write;
    newEntry.dest   = SB_DEST_W'(id_dest);
    newEntry.isLoad = id_mem_read;
  end

  // Scoreboard shift, registered EX selects and saturating counters.
  // On a taken branch the EX-stage instruction is younger than the branch,
  // so it is dropped instead of advancing into MEM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < SB_DEPTH; k++) sb[k] <= '0;
      ex_fwd_a  <= FWD_SRC_IDEX;
      ex_fwd_b  <= FWD_SRC_IDEX;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb[0] <= newEntry;
      sb[1] <= mem_branch_taken ? '0 : sb[0];
      sb[2] <= sb[1];
      ex_fwd_a <= enterValid ? nextFwdA : FWD_SRC_IDEX;
      ex_fwd_b <= enterValid ? nextFwdB : FWD_SRC_IDEX;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (mem_branch_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard. Two instances: dutFwd (forwarding,
// 32-bit counters) and dutStallOnly (no forwarding, 4-bit counters so the
// saturation point is reachable). Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       idValid;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUsesRs;
    logic       idUsesRt;
    logic [4:0] idDest;
    logic       idRegWrite;
    logic       idMemRead;
    logic       memBranchTaken;
  } stim_t;

  localparam stim_t IDLE = '0;

  logic  clk = 1'b0;
  logic  reset;
  stim_t fIn;
  stim_t sIn;

  logic        fStall, fFlushIfId, fFlushIdEx, fFlushExMem, fIdFwdA, fIdFwdB;
  logic [1:0]  fExFwdA, fExFwdB;
  logic [31:0] fStallCnt, fFlushCnt;

  logic        sStall, sFlushIfId, sFlushIdEx, sFlushExMem, sIdFwdA, sIdFwdB;
  logic [1:0]  sExFwdA, sExFwdB;
  logic [3:0]  sStallCnt, sFlushCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(32)) dutFwd (
    .clk(clk), .reset(reset),
    .id_valid(fIn.idValid), .id_rs(fIn.idRs), .id_rt(fIn.idRt),
    .id_uses_rs(fIn.idUsesRs), .id_uses_rt(fIn.idUsesRt),
    .id_dest(fIn.idDest), .id_reg_write(fIn.idRegWrite),
    .id_mem_read(fIn.idMemRead), .mem_branch_taken(fIn.memBranchTaken),
    .stall(fStall), .flush_if_id(fFlushIfId), .flush_id_ex(fFlushIdEx),
    .flush_ex_mem(fFlushExMem), .id_fwd_a(fIdFwdA), .id_fwd_b(fIdFwdB),
    .ex_fwd_a(fExFwdA), .ex_fwd_b(fExFwdB),
    .stall_cnt(fStallCnt), .flush_cnt(fFlushCnt)
  );

  hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(4)) dutStallOnly (
    .clk(clk), .reset(reset),
    .id_valid(sIn.idValid), .id_rs(sIn.idRs), .id_rt(sIn.idRt),
    .id_uses_rs(sIn.idUsesRs), .id_uses_rt(sIn.idUsesRt),
    .id_dest(sIn.idDest), .id_reg_write(sIn.idRegWrite),
    .id_mem_read(sIn.idMemRead), .mem_branch_taken(sIn.memBranchTaken),
    .stall(sStall), .flush_if_id(sFlushIfId), .flush_id_ex(sFlushIdEx),
    .flush_ex_mem(sFlushExMem), .id_fwd_a(sIdFwdA), .id_fwd_b(sIdFwdB),
    .ex_fwd_a(sExFwdA), .ex_fwd_b(sExFwdB),
    .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
  );

  // Builds one decoded ID instruction
  function automatic stim_t instr(input bit v, input int rs, input int rt,
                                  input bit ur, input bit ut, input int dest,
                                  input bit rw, input bit mr, input bit br);
    stim_t s;
    s.idValid        = v;
    s.idRs           = 5'(rs);
    s.idRt           = 5'(rt);
    s.idUsesRs       = ur;
    s.idUsesRt       = ut;
    s.idDest         = 5'(dest);
    s.idRegWrite     = rw;
    s.idMemRead      = mr;
    s.memBranchTaken = br;
    return s;
  endfunction

  // Drives one cycle of ID inputs into the chosen instance
  task automatic applyStimulus(input bit stallOnly, input stim_t s);
    @(negedge clk);
    if (stallOnly) sIn = s;
    else           fIn = s;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic drain(input bit stallOnly);
    repeat (3) applyStimulus(stallOnly, IDLE);
  endtask

  // Instruction vectors
  stim_t lw8, add9, add9Br, add3, sub4, add0, add1, beq, or4, i3;

  initial begin
    lw8    = instr(1, 2, 0, 1, 0, 8, 1, 1, 0);  // lw  $8, 0($2)
    add9   = instr(1, 8, 8, 1, 1, 9, 1, 0, 0);  // add $9, $8, $8
    add9Br = instr(1, 8, 8, 1, 1, 9, 1, 0, 1);  // same, branch taken in MEM
    add3   = instr(1, 1, 2, 1, 1, 3, 1, 0, 0);  // add $3, $1, $2
    sub4   = instr(1, 3, 5, 1, 1, 4, 1, 0, 0);  // sub $4, $3, $5
    add0   = instr(1, 1, 2, 1, 1, 0, 1, 0, 0);  // add $0, $1, $2
    add1   = instr(1, 0, 0, 1, 1, 1, 1, 0, 0);  // add $1, $0, $0
    beq    = instr(1, 1, 2, 1, 1, 0, 0, 0, 0);  // beq $1, $2
    or4    = instr(1, 3, 3, 1, 1, 4, 1, 0, 0);  // or  $4, $3, $3
    i3     = instr(1, 3, 3, 1, 1, 3, 1, 0, 0);  // add $3, $3, $3

    // ---- reset with random inputs ----
    reset = 1'b0;
    fIn   = IDLE;
    sIn   = IDLE;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] r;
      @(negedge clk);
      r   = $urandom;
      fIn = r[$bits(stim_t)-1:0];
      r   = $urandom;
      sIn = r[$bits(stim_t)-1:0];
      #1;
      checkOutput("rstStall",      fStall,      0);
      checkOutput("rstFlushIfId",  fFlushIfId,  0);
      checkOutput("rstFlushIdEx",  fFlushIdEx,  0);
      checkOutput("rstFlushExMem", fFlushExMem, 0);
      checkOutput("rstIdFwdA",     fIdFwdA,     0);
      checkOutput("rstIdFwdB",     fIdFwdB,     0);
      checkOutput("rstExFwdA",     fExFwdA,     0);
      checkOutput("rstExFwdB",     fExFwdB,     0);
      checkOutput("rstSoStall",    sStall,      0);
      checkOutput("rstSoFlush",    sFlushExMem, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    fIn   = IDLE;
    sIn   = IDLE;
    #1;
    checkOutput("rstStallCnt",   fStallCnt, 0);
    checkOutput("rstFlushCnt",   fFlushCnt, 0);
    checkOutput("rstSoStallCnt", sStallCnt, 0);
    checkOutput("rstSoFlushCnt", sFlushCnt, 0);

    // ---- load-use: lw $8 ; add $9,$8,$8 ----
    applyStimulus(0, lw8);
    checkOutput("luNoStallLw", fStall, 0);
    applyStimulus(0, add9);
    checkOutput("luStall", fStall, 1);
    applyStimulus(0, add9);
    checkOutput("luStallEnd", fStall, 0);
    checkOutput("luStallCnt", fStallCnt, 1);
    applyStimulus(0, IDLE);
    checkOutput("luExFwdA", fExFwdA, 2);
    checkOutput("luExFwdB", fExFwdB, 2);
    drain(0);

    // ---- back-to-back ALU ----
    applyStimulus(0, add3);
    applyStimulus(0, sub4);
    checkOutput("b2bStall", fStall, 0);
    applyStimulus(0, IDLE);
    checkOutput("b2bExFwdA", fExFwdA, 1);
    checkOutput("b2bExFwdB", fExFwdB, 0);
    drain(0);

    // ---- one bubble between producer and consumer ----
    applyStimulus(0, add3);
    applyStimulus(0, IDLE);
    applyStimulus(0, sub4);
    checkOutput("gap1Stall", fStall, 0);
    checkOutput("gap1IdFwdA", fIdFwdA, 0);
    applyStimulus(0, IDLE);
    checkOutput("gap1ExFwdA", fExFwdA, 2);
    drain(0);

    // ---- two bubbles: producer in WB, bypassed in ID ----
    applyStimulus(0, add3);
    applyStimulus(0, IDLE);
    applyStimulus(0, IDLE);
    applyStimulus(0, sub4);
    checkOutput("gap2IdFwdA", fIdFwdA, 1);
    checkOutput("gap2IdFwdB", fIdFwdB, 0);
    applyStimulus(0, IDLE);
    checkOutput("gap2ExFwdA", fExFwdA, 0);
    drain(0);

    // ---- register 0 is never a hazard ----
    applyStimulus(0, add0);
    applyStimulus(0, add1);
    checkOutput("r0Stall", fStall, 0);
    checkOutput("r0IdFwdA", fIdFwdA, 0);
    applyStimulus(0, IDLE);
    checkOutput("r0ExFwdA", fExFwdA, 0);
    checkOutput("r0ExFwdB", fExFwdB, 0);
    drain(0);

    // ---- taken branch while a load-use hazard sits in ID ----
    applyStimulus(0, beq);
    applyStimulus(0, lw8);
    applyStimulus(0, add9Br);
    checkOutput("brStall",      fStall,      0);
    checkOutput("brFlushIfId",  fFlushIfId,  1);
    checkOutput("brFlushIdEx",  fFlushIdEx,  1);
    checkOutput("brFlushExMem", fFlushExMem, 1);
    applyStimulus(0, add9);
    checkOutput("brPostStall",  fStall,     0);
    checkOutput("brPostFlush",  fFlushIfId, 0);
    checkOutput("brFlushCnt",   fFlushCnt,  1);
    checkOutput("brStallCnt",   fStallCnt,  1);
    checkOutput("brPostExFwdA", fExFwdA,    0);
    applyStimulus(0, IDLE);
    checkOutput("brSb1GoneA", fExFwdA, 0);
    checkOutput("brSb1GoneB", fExFwdB, 0);
    drain(0);

    // ---- stall-only mode: add $3 ; or $4,$3,$3 ----
    applyStimulus(1, add3);
    checkOutput("soFirst", sStall, 0);
    applyStimulus(1, or4);
    checkOutput("soStall1", sStall, 1);
    checkOutput("soIdFwd1", sIdFwdA, 0);
    applyStimulus(1, or4);
    checkOutput("soStall2", sStall, 1);
    applyStimulus(1, or4);
    checkOutput("soStall3", sStall, 1);
    checkOutput("soIdFwd3", sIdFwdA, 0);
    applyStimulus(1, or4);
    checkOutput("soStallEnd", sStall, 0);
    checkOutput("soStallCnt", sStallCnt, 3);
    applyStimulus(1, IDLE);
    checkOutput("soExFwdA", sExFwdA, 0);
    checkOutput("soExFwdB", sExFwdB, 0);
    checkOutput("soStallCnt2", sStallCnt, 3);

    // ---- saturation: dependent chain, 3 stalls per instruction ----
    repeat (13) applyStimulus(1, i3);
    checkOutput("satMidStall", sStall, 0);
    checkOutput("satMidCnt", sStallCnt, 12);
    repeat (12) applyStimulus(1, i3);
    applyStimulus(1, IDLE);
    checkOutput("satCnt", sStallCnt, 15);
    checkOutput("satFlushCnt", sFlushCnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
